// File: rtl/dffp_sync_pkg.sv
// Constants shared by dffp_sync and the CPU register files built from it.
package dffp_sync_pkg;

  // Value every storage bit takes on a reset edge.
  localparam logic RESET_VALUE = 1'b0;

endpackage : dffp_sync_pkg

// File: rtl/dffp_sync_d_latch.sv
// Level-sensitive gated D latch with true and complement outputs.
module d_latch (
  input  logic en,
  input  logic d,
  output logic q,
  output logic qb
);

  logic state_q;

  // Behavioural equivalent of the NAND gate pair feeding a cross-coupled NAND
  // pair: transparent while en is high, holding its value while en is low.
  always_latch begin
    if (en) begin
      state_q <= d;
    end
  end

  assign q  = state_q;
  assign qb = ~state_q;

endmodule : d_latch

// File: rtl/dffp_sync.sv
// Rising-edge D flip-flop with complementary outputs and synchronous active-high
// reset, built per bit from a master/slave pair of gated D latches.
module dffp_sync
  import dffp_sync_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
);

  logic [WIDTH-1:0] d_eff;
  logic [WIDTH-1:0] master_q;
  logic [WIDTH-1:0] master_qb;
  logic             unused_master_qb;

  // Reset is folded into the data path ahead of the master latch, so it is
  // only captured where d would be: on the rising edge.
  always_comb begin
    d_eff = d;
    if (srst) begin
      d_eff = {WIDTH{RESET_VALUE}};
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      d_latch u_master (
        .en (~clk),
        .d  (d_eff[gi]),
        .q  (master_q[gi]),
        .qb (master_qb[gi])
      );

      d_latch u_slave (
        .en (clk),
        .d  (master_q[gi]),
        .q  (q[gi]),
        .qb (qb[gi])
      );
    end
  endgenerate

  // The slave is fed from the master's true output alone.
  assign unused_master_qb = ^master_qb;

endmodule : dffp_sync

// File: tb/tb_dffp_sync.sv
// Self-checking bench for dffp_sync with a 1-bit and a 4-bit instance.
`timescale 1ns/1ps
module tb_dffp_sync;

  logic       clk;
  logic       srst;
  logic [0:0] d1;
  logic [0:0] q1;
  logic [0:0] qb1;
  logic [3:0] d4;
  logic [3:0] q4;
  logic [3:0] qb4;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what each flop must hold after the most recent edge.
  logic [0:0] exp1;
  logic [3:0] exp4;

  dffp_sync #(.WIDTH(1)) dut1 (
    .clk  (clk),
    .srst (srst),
    .d    (d1),
    .q    (q1),
    .qb   (qb1)
  );

  dffp_sync #(.WIDTH(4)) dut4 (
    .clk  (clk),
    .srst (srst),
    .d    (d4),
    .q    (q4),
    .qb   (qb4)
  );

  initial begin
    clk = 1'b0;
    forever #17 clk = ~clk;
  end

  // Inputs change with the falling edge; the model captures at the rising edge
  // and the outputs are sampled 1 ns later.
  task automatic step(input logic r, input logic v1, input logic [3:0] v4);
    @(negedge clk);
    srst = r;
    d1   = v1;
    d4   = v4;
    @(posedge clk);
    exp1 = r ? 1'b0 : v1;
    exp4 = r ? 4'b0000 : v4;
    #1;
  endtask

  task automatic test_reset();
    srst = 1'b1;
    d1   = 1'b1;
    d4   = 4'b1111;
    @(posedge clk);
    #1;
    n_checks += 4;
    if (q1 !== 1'b0) begin n_fail++; $display("FAIL reset_q1: got %b want 0", q1); end
    if (qb1 !== 1'b1) begin n_fail++; $display("FAIL reset_qb1: got %b want 1", qb1); end
    if (q4 !== 4'b0000) begin n_fail++; $display("FAIL reset_q4: got %b want 0000", q4); end
    if (qb4 !== 4'b1111) begin n_fail++; $display("FAIL reset_qb4: got %b want 1111", qb4); end
    $display("txn reset: q1=%b qb1=%b q4=%b qb4=%b", q1, qb1, q4, qb4);
  endtask

  task automatic test_hold0();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 4'b0000);
      n_checks += 2;
      if (q1 !== 1'b0) begin n_fail++; $display("FAIL hold0_q edge%0d: got %b want 0", i, q1); end
      if (qb1 !== 1'b1) begin n_fail++; $display("FAIL hold0_qb edge%0d: got %b want 1", i, qb1); end
      $display("txn hold0 edge%0d: q1=%b qb1=%b", i, q1, qb1);
    end
  endtask

  task automatic test_set();
    @(negedge clk);
    srst = 1'b0;
    d1   = 1'b1;
    #15;
    n_checks++;
    if (q1 !== 1'b0) begin n_fail++; $display("FAIL set_before_edge: got %b want 0", q1); end
    @(posedge clk);
    #1;
    n_checks += 2;
    if (q1 !== 1'b1) begin n_fail++; $display("FAIL set_q: got %b want 1", q1); end
    if (qb1 !== 1'b0) begin n_fail++; $display("FAIL set_qb: got %b want 0", qb1); end
    $display("txn set: q1=%b qb1=%b", q1, qb1);
  endtask

  task automatic test_hold1_glitch();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, d4);
      n_checks += 2;
      if (q1 !== 1'b1) begin n_fail++; $display("FAIL hold1_q edge%0d: got %b want 1", i, q1); end
      if (qb1 !== 1'b0) begin n_fail++; $display("FAIL hold1_qb edge%0d: got %b want 0", i, qb1); end
    end
    // Toggle d while clk is high; the master is closed so nothing moves.
    d1 = 1'b0; #4;
    d1 = 1'b1; #4;
    d1 = 1'b0; #4;
    n_checks++;
    if (q1 !== 1'b1) begin n_fail++; $display("FAIL hold1_glitch: got %b want 1", q1); end
    d1 = 1'b1;
    $display("txn hold1+glitch: q1=%b qb1=%b", q1, qb1);
  endtask

  task automatic test_clear_from_1();
    step(1'b1, 1'b1, 4'b1111);
    n_checks += 2;
    if (q1 !== 1'b0) begin n_fail++; $display("FAIL clear_q: got %b want 0", q1); end
    if (qb1 !== 1'b1) begin n_fail++; $display("FAIL clear_qb: got %b want 1", qb1); end
    step(1'b0, 1'b1, 4'b1111);
    n_checks++;
    if (q1 !== 1'b1) begin n_fail++; $display("FAIL reload_q: got %b want 1", q1); end
    $display("txn clear/reload: q1=%b qb1=%b", q1, qb1);
  endtask

  task automatic test_width4();
    step(1'b0, 1'b0, 4'b1010);
    n_checks += 2;
    if (q4 !== 4'b1010) begin n_fail++; $display("FAIL w4_load_q: got %b want 1010", q4); end
    if (qb4 !== 4'b0101) begin n_fail++; $display("FAIL w4_load_qb: got %b want 0101", qb4); end
    step(1'b1, 1'b1, 4'b1010);
    n_checks += 2;
    if (q4 !== 4'b0000) begin n_fail++; $display("FAIL w4_reset_q: got %b want 0000", q4); end
    if (qb4 !== 4'b1111) begin n_fail++; $display("FAIL w4_reset_qb: got %b want 1111", qb4); end
    $display("txn width4: q4=%b qb4=%b", q4, qb4);
  endtask

  task automatic test_random();
    logic       r;
    logic [3:0] v;
    logic [0:0] prev1;
    logic [3:0] prev4;
    for (int i = 0; i < 40; i++) begin
      r     = ($urandom_range(3) == 0);
      v     = 4'($urandom);
      prev1 = exp1;
      prev4 = exp4;
      @(negedge clk);
      srst = r;
      d1   = v[0];
      d4   = v;
      #15;
      n_checks += 2;
      if (q4 !== prev4) begin n_fail++; $display("FAIL rnd%0d_pre_edge q4: got %b want %b", i, q4, prev4); end
      if (q1 !== prev1) begin n_fail++; $display("FAIL rnd%0d_pre_edge q1: got %b want %b", i, q1, prev1); end
      @(posedge clk);
      exp1 = r ? 1'b0 : v[0];
      exp4 = r ? 4'b0000 : v;
      #1;
      n_checks += 3;
      if (q4 !== exp4) begin n_fail++; $display("FAIL rnd%0d q4: got %b want %b", i, q4, exp4); end
      if (qb4 !== ~exp4) begin n_fail++; $display("FAIL rnd%0d qb4: got %b want %b", i, qb4, ~exp4); end
      if (q1 !== exp1) begin n_fail++; $display("FAIL rnd%0d q1: got %b want %b", i, q1, exp1); end
      // Glitch both inputs during the high phase.
      #3;
      d4   = 4'($urandom);
      d1   = 1'($urandom);
      srst = 1'($urandom);
      #10;
      n_checks++;
      if (q4 !== exp4) begin n_fail++; $display("FAIL rnd%0d glitch q4: got %b want %b", i, q4, exp4); end
      $display("txn rnd%0d: srst=%b d=%b -> q4=%b qb4=%b q1=%b", i, r, v, q4, qb4, q1);
    end
  endtask

  initial begin
    exp1 = 1'b0;
    exp4 = 4'b0000;
    test_reset();
    test_hold0();
    test_set();
    test_hold1_glitch();
    test_clear_from_1();
    test_width4();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_dffp_sync
